// File: rtl/sequence_pattern_transmitter.sv
// Serial pattern source: shifts a latched PAT_W-bit pattern out MSB first,
// repeat_n times, with an optional GAP-cycle idle gap between repetitions.
// Every output is a flop, so each output reflects the state entered at the
// most recent edge.
module sequence_pattern_transmitter #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             abort,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;   // index of the bit currently on out_bit
    logic [CNT_W-1:0]   rep_q, rep_d;           // repetitions still owed, incl. current
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;   // gap cycles left after the current one
    logic               out_bit_q, out_bit_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // State and registered outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pat_q       <= '0;
            bit_idx_q   <= '0;
            rep_q       <= '0;
            gap_cnt_q   <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            bit_idx_q   <= bit_idx_d;
            rep_q       <= rep_d;
            gap_cnt_q   <= gap_cnt_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next state and counters; pattern/count only change on an accepted start.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        bit_idx_d = bit_idx_q;
        rep_d     = rep_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_d     = pattern_in;
                    rep_d     = repeat_n;
                    bit_idx_d = BIT_MSB;
                    state_d   = (repeat_n == '0) ? S_DONE : S_SEND;
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bit_idx_q != '0) begin
                    bit_idx_d = bit_idx_q - 1'b1;
                end else begin
                    // End of a repetition: rep_q is never 0 here, so no wrap.
                    rep_d = rep_q - 1'b1;
                    if (rep_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end else if (GAP > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = GAP_LAST;
                    end else begin
                        bit_idx_d = BIT_MSB;
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gap_cnt_q == '0) begin
                    state_d   = S_SEND;
                    bit_idx_d = BIT_MSB;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the state being entered; out_bit forced low when not valid.
    always_comb begin
        out_valid_d = (state_d == S_SEND);
        busy_d      = (state_d == S_SEND) || (state_d == S_GAP);
        done_d      = (state_d == S_DONE);
        out_bit_d   = out_valid_d ? pat_d[bit_idx_d] : 1'b0;
    end

    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sequence_pattern_transmitter.sv
// Directed bench: one instance with GAP=0 and one with GAP=2 share stimulus;
// each test checks the instance whose gap setting it targets.
module tb_sequence_pattern_transmitter;

    logic       clk, reset, start, abort;
    logic [4:0] pattern_in;
    logic [3:0] repeat_n;
    logic       ob0, ov0, bs0, dn0;
    logic       ob2, ov2, bs2, dn2;
    logic [3:0] o0, o2;

    int n_cmp = 0;
    int n_err = 0;

    sequence_pattern_transmitter #(.PAT_W(5), .CNT_W(4), .GAP(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .pattern_in(pattern_in),
        .repeat_n(repeat_n), .abort(abort),
        .out_bit(ob0), .out_valid(ov0), .busy(bs0), .done(dn0));

    sequence_pattern_transmitter #(.PAT_W(5), .CNT_W(4), .GAP(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .pattern_in(pattern_in),
        .repeat_n(repeat_n), .abort(abort),
        .out_bit(ob2), .out_valid(ov2), .busy(bs2), .done(dn2));

    // Observed output vector {out_bit, out_valid, busy, done}.
    assign o0 = {ob0, ov0, bs0, dn0};
    assign o2 = {ob2, ov2, bs2, dn2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Moore 11011 detector fed by the GAP=0 instance's stream.
    logic [4:0] det_sh;
    logic       det, det_prev;
    int         det_rises = 0;
    always @(posedge clk) begin
        if (reset) begin
            det_sh   <= '0;
            det      <= 1'b0;
            det_prev <= 1'b0;
        end else begin
            if (ov0) det_sh <= {det_sh[3:0], ob0};
            det      <= (det_sh == 5'b11011);
            det_prev <= det;
            if (det && !det_prev) det_rises <= det_rises + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single repetition started at cycle 0: bits in cycles 1-5, done in 6.
    function automatic logic [3:0] exp_single(input logic [4:0] pat, input int c);
        if (c >= 1 && c <= 5) return {pat[5-c], 3'b110};
        if (c == 6) return 4'b0001;
        return 4'b0000;
    endfunction

    // 10110 x3 with a 2-cycle gap: 7-cycle period, done in cycle 20.
    function automatic logic [3:0] exp_rep3(input int c);
        logic [4:0] pat;
        int p;
        pat = 5'b10110;
        if (c == 20) return 4'b0001;
        if (c < 1 || c > 20) return 4'b0000;
        p = (c - 1) % 7;
        if (p < 5) return {pat[4-p], 3'b110};
        return 4'b0010;
    endfunction

    task automatic launch(input logic [4:0] pat, input logic [3:0] n);
        pattern_in = pat;
        repeat_n   = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        int snap;
        reset = 1'b1; start = 1'b0; abort = 1'b0; pattern_in = '0; repeat_n = '0;
        tick(); tick();
        chk("reset g0", o0, 4'b0000);
        chk("reset g2", o2, 4'b0000);
        reset = 1'b0;
        tick();

        // Single 11011 repetition, both instances identical; loopback detector.
        snap = det_rises;
        launch(5'b11011, 4'd1);
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("single g0 c%0d", c), o0, exp_single(5'b11011, c));
            chk($sformatf("single g2 c%0d", c), o2, exp_single(5'b11011, c));
            tick();
        end
        chk("loopback detect count", det_rises - snap, 1);

        // Three repetitions with gaps.
        launch(5'b10110, 4'd3);
        for (int c = 1; c <= 21; c++) begin
            chk($sformatf("rep3 gap c%0d", c), o2, exp_rep3(c));
            tick();
        end

        // repeat_n = 0: done only, never valid or busy.
        launch(5'b11111, 4'd0);
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("rep0 c%0d", c), o0, (c == 1) ? 4'b0001 : 4'b0000);
            tick();
        end

        // start re-pulsed with a new pattern during SEND is ignored.
        launch(5'b11011, 4'd1);
        for (int c = 1; c <= 9; c++) begin
            if (c == 2) begin start = 1'b1; pattern_in = 5'b00000; repeat_n = 4'd5; end
            if (c == 3) start = 1'b0;
            chk($sformatf("restart ign c%0d", c), o0, exp_single(5'b11011, c));
            tick();
        end

        // abort in cycle 3: idle from cycle 4, no done pulse.
        launch(5'b11011, 4'd1);
        for (int c = 1; c <= 8; c++) begin
            if (c == 3) abort = 1'b1;
            if (c == 4) abort = 1'b0;
            chk($sformatf("abort c%0d", c), o0, (c <= 3) ? exp_single(5'b11011, c) : 4'b0000);
            tick();
        end

        // Reset during the first gap, then a clean transfer.
        launch(5'b10110, 4'd3);
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("pre-reset c%0d", c), o2, exp_rep3(c));
            if (c == 6) reset = 1'b1;
            tick();
        end
        chk("reset mid-gap g2", o2, 4'b0000);
        reset = 1'b0;
        tick();
        chk("idle after reset", o2, 4'b0000);
        launch(5'b11011, 4'd1);
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("post-reset c%0d", c), o2, exp_single(5'b11011, c));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
